// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared image geometry and writer state type for the VGA image RAM
package vga_pkg;

    // Image geometry shared by the frame buffer writer and the pixel printer
    localparam int IMG_W     = 100;
    localparam int IMG_H     = 100;
    localparam int HDR_WORDS = 3;
    localparam int PIX_BASE  = HDR_WORDS;
    localparam int PIX_LAST  = PIX_BASE + IMG_W * IMG_H - 1;

    // Image RAM geometry
    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        PIXELS = 2'd2,
        DONE   = 2'd3
    } fbw_state_t;

endpackage

// File: rtl/frame_buffer_writer.sv
// rtl/frame_buffer_writer.sv - writes header plus one pixel stream frame into the image RAM
module frame_buffer_writer #(
    parameter int IMG_W     = vga_pkg::IMG_W,
    parameter int IMG_H     = vga_pkg::IMG_H,
    parameter int HDR_WORDS = vga_pkg::HDR_WORDS,
    parameter int ADDR_W    = vga_pkg::ADDR_W,
    parameter int DATA_W    = vga_pkg::DATA_W
) (
    input  logic              vga_clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err_len
);

    import vga_pkg::*;

    // Pixels follow the header directly; the pixel counter runs 0..NPIX-1
    localparam int BASE_ADDR = HDR_WORDS;
    localparam int NPIX      = IMG_W * IMG_H;
    localparam int HIDX_W    = $clog2(HDR_WORDS + 1);

    fbw_state_t        state_q, state_d;
    logic [HIDX_W-1:0] hdr_idx_q, hdr_idx_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [7:0]        frame_id_q, frame_id_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              err_len_q, err_len_d;
    logic              final_beat;

    // Header word contents: width, height, frame id, then zero padding
    function automatic logic [DATA_W-1:0] hdr_word(input logic [HIDX_W-1:0] idx,
                                                   input logic [7:0]        fid);
        logic [DATA_W-1:0] w;
        w = '0;
        case (idx)
            HIDX_W'(0): w = DATA_W'(IMG_W);
            HIDX_W'(1): w = DATA_W'(IMG_H);
            HIDX_W'(2): w = DATA_W'(fid);
            default:    w = '0;
        endcase
        return w;
    endfunction

    // Next-state, counters and the RAM write port contents for the coming edge
    always_comb begin
        state_d     = state_q;
        hdr_idx_d   = hdr_idx_q;
        cnt_d       = cnt_q;
        frame_id_d  = frame_id_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_len_d   = err_len_q;
        final_beat  = (cnt_q == ADDR_W'(NPIX - 1));

        if (abort) begin
            // Abort wins over start and beats; the partial frame stays in RAM
            state_d   = IDLE;
            hdr_idx_d = '0;
            cnt_d     = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d   = HDR;
                        err_len_d = 1'b0;
                        hdr_idx_d = '0;
                        cnt_d     = '0;
                    end
                end
                HDR: begin
                    mem_we_d    = 1'b1;
                    mem_addr_d  = ADDR_W'(hdr_idx_q);
                    mem_wdata_d = hdr_word(hdr_idx_q, frame_id_q);
                    if (hdr_idx_q == HIDX_W'(HDR_WORDS - 1)) begin
                        state_d   = PIXELS;
                        hdr_idx_d = '0;
                    end else begin
                        hdr_idx_d = hdr_idx_q + HIDX_W'(1);
                    end
                end
                PIXELS: begin
                    // s_ready is high for the whole state, so s_valid alone is a beat
                    if (s_valid) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = ADDR_W'(BASE_ADDR) + cnt_q;
                        mem_wdata_d = s_data;
                        cnt_d       = cnt_q + ADDR_W'(1);
                        if (final_beat || s_last) begin
                            state_d = DONE;
                        end
                        if (final_beat != s_last) begin
                            err_len_d = 1'b1;
                        end
                    end
                end
                DONE: begin
                    frame_id_d = frame_id_q + 8'd1;
                    state_d    = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, counters and registered RAM write port
    always_ff @(posedge vga_clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            hdr_idx_q   <= '0;
            cnt_q       <= '0;
            frame_id_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            err_len_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_idx_q   <= hdr_idx_d;
            cnt_q       <= cnt_d;
            frame_id_q  <= frame_id_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            err_len_q   <= err_len_d;
        end
    end

    // Status outputs decoded from state; done is suppressed when aborted in DONE
    always_comb begin
        s_ready   = (state_q == PIXELS);
        busy      = (state_q == HDR) || (state_q == PIXELS);
        done      = (state_q == DONE) && !abort;
        mem_we    = mem_we_q;
        mem_addr  = mem_addr_q;
        mem_wdata = mem_wdata_q;
        err_len   = err_len_q;
    end

endmodule

// File: tb/tb_frame_buffer_writer.sv
// tb/tb_frame_buffer_writer.sv - self-checking bench for frame_buffer_writer
module tb_frame_buffer_writer;

    localparam int TOTAL    = vga_pkg::IMG_W * vga_pkg::IMG_H;
    localparam int PIX_LAST = vga_pkg::PIX_LAST;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    typedef struct {
        int last_at;    // beat carrying s_last, -1 for none
        int valid_pct;  // probability of s_valid per cycle
        int abort_at;   // beat index where abort+start are raised, -1 for none
        int start_mid;  // beat index where a stray start is pulsed, -1 for none
        int exp_done;
        int exp_err;
    } frame_vec_t;

    logic       vga_clk = 1'b0;
    logic       rst     = 1'b0;
    logic       start   = 1'b0;
    logic       abort   = 1'b0;
    logic       s_valid = 1'b0;
    logic [7:0] s_data  = 8'd0;
    logic       s_last  = 1'b0;
    logic       s_ready;
    logic       mem_we;
    logic [13:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       busy;
    logic       done;
    logic       err_len;

    int  n_tests = 0;
    int  n_fail  = 0;
    int  fid     = 0;
    int  done_cnt;
    int  max_addr;
    wr_t wr_q[$];
    wr_t exp_q[$];

    frame_buffer_writer dut (
        .vga_clk  (vga_clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .s_last   (s_last),
        .s_ready  (s_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .done     (done),
        .err_len  (err_len)
    );

    always #5 vga_clk = ~vga_clk;

    // Write log and done counter, sampled away from the rising edge
    always @(negedge vga_clk) begin
        if (mem_we) begin
            wr_q.push_back('{int'(mem_addr), int'(mem_wdata)});
            if (int'(mem_addr) > max_addr) max_addr = int'(mem_addr);
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    // Drive one frame and compare the RAM write log with the expected frame image
    task automatic run_frame(input string tag, input frame_vec_t v);
        int  beat;
        int  cyc;
        bit  fin;
        bit  aborted;
        bit  acc;
        bit  mid_done;
        int  mism;
        int  n;
        wr_q.delete();
        exp_q.delete();
        done_cnt = 0;
        max_addr = 0;
        @(posedge vga_clk); #1;
        start = 1'b1;
        @(posedge vga_clk); #1;
        start = 1'b0;
        check({tag, "_err_cleared"}, int'(err_len), 0);
        check({tag, "_busy_after_start"}, int'(busy), 1);

        exp_q.push_back('{0, vga_pkg::IMG_W});
        exp_q.push_back('{1, vga_pkg::IMG_H});
        exp_q.push_back('{2, fid % 256});

        beat = 0; cyc = 0; fin = 0; aborted = 0; mid_done = 0;
        while (!fin && cyc < 40000) begin
            s_valid = ($urandom_range(99) < v.valid_pct);
            s_data  = 8'($urandom);
            s_last  = (beat == v.last_at);
            if (beat == v.abort_at) begin
                abort   = 1'b1;
                start   = 1'b1;
                s_valid = 1'b1;
            end
            if (beat == v.start_mid && !mid_done) begin
                start    = 1'b1;
                mid_done = 1;
            end
            acc = s_valid && s_ready;
            @(posedge vga_clk); #1;
            if (abort) begin
                fin     = 1;
                aborted = 1;
            end else if (acc) begin
                exp_q.push_back('{vga_pkg::PIX_BASE + beat, int'(s_data)});
                if (s_last || beat == TOTAL - 1) fin = 1;
                beat++;
            end
            abort = 1'b0;
            start = 1'b0;
            cyc++;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (!fin) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: frame did not finish, beats %0d", tag, beat);
        end
        if (aborted) begin
            check({tag, "_idle_busy"}, int'(busy), 0);
            check({tag, "_idle_ready"}, int'(s_ready), 0);
        end
        repeat (4) @(posedge vga_clk);
        #1;
        check({tag, "_wr_count"}, wr_q.size(), exp_q.size());
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        mism = -1;
        for (int i = 0; i < n; i++) begin
            if (mism < 0 && (wr_q[i].addr != exp_q[i].addr || wr_q[i].data != exp_q[i].data))
                mism = i;
        end
        n_tests++;
        if (mism >= 0) begin
            n_fail++;
            $display("FAIL %s_write_stream: idx %0d got addr %0d data %0d, want addr %0d data %0d",
                     tag, mism, wr_q[mism].addr, wr_q[mism].data, exp_q[mism].addr, exp_q[mism].data);
        end
        check({tag, "_done_pulses"}, done_cnt, v.exp_done);
        check({tag, "_err_len"}, int'(err_len), v.exp_err);
        check({tag, "_addr_bound"}, int'(max_addr <= PIX_LAST), 1);
        check({tag, "_busy_end"}, int'(busy), 0);
        if (!aborted) fid++;
    endtask

    frame_vec_t vecs[6];

    initial begin
        vecs[0] = '{9999, 100, -1,  -1, 1, 0};  // full frame, continuous
        vecs[1] = '{9999,  70, -1, 500, 1, 0};  // gaps plus stray start while busy
        vecs[2] = '{4999, 100, -1,  -1, 1, 1};  // short frame
        vecs[3] = '{  -1, 100, -1,  -1, 1, 1};  // missing s_last
        vecs[4] = '{  -1, 100, 20,  -1, 0, 0};  // abort with start at beat 20
        vecs[5] = '{9999, 100, -1,  -1, 1, 0};  // frame id unchanged by abort

        // Reset state
        #1;
        check("rst_mem_we", int'(mem_we), 0);
        check("rst_mem_addr", int'(mem_addr), 0);
        check("rst_mem_wdata", int'(mem_wdata), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ready", int'(s_ready), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err_len), 0);
        repeat (2) @(posedge vga_clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge vga_clk);
        #1;
        check("idle_ready", int'(s_ready), 0);

        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("frame%0d", i), vecs[i]);
        end

        // Asynchronous reset in the middle of the pixel phase
        @(posedge vga_clk); #1;
        start = 1'b1;
        @(posedge vga_clk); #1;
        start   = 1'b0;
        s_valid = 1'b1;
        repeat (60) @(posedge vga_clk);
        #2 rst = 1'b0;
        #1;
        check("midrst_mem_we", int'(mem_we), 0);
        check("midrst_mem_addr", int'(mem_addr), 0);
        check("midrst_mem_wdata", int'(mem_wdata), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_ready", int'(s_ready), 0);
        check("midrst_done", int'(done), 0);
        s_valid = 1'b0;
        @(posedge vga_clk); #1;
        rst = 1'b1;
        fid = 0;
        run_frame("post_reset", '{9, 100, -1, -1, 1, 1});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
